// File: rtl/sync_filter_bank.sv
// rtl/sync_filter_bank.sv - multi-channel synchroniser plus stability filter with edge strobes
module sync_filter_bank #(
  parameter int   NB_CHANNELS   = 4,
  parameter int   NB_STAGES     = 2,
  parameter int   FILTER_CYCLES = 4,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [NB_CHANNELS-1:0] i_data,
  output logic [NB_CHANNELS-1:0] o_data,
  output logic [NB_CHANNELS-1:0] o_rise,
  output logic [NB_CHANNELS-1:0] o_fall,
  output logic [NB_CHANNELS-1:0] o_busy,
  output logic                   o_event
);

  localparam int            CW        = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(FILTER_CYCLES - 1);

  logic [NB_CHANNELS-1:0] r_sync [NB_STAGES];
  logic [CW-1:0]          r_cnt  [NB_CHANNELS];
  logic [CW-1:0]          w_next_cnt [NB_CHANNELS];
  logic [NB_CHANNELS-1:0] w_s;
  logic [NB_CHANNELS-1:0] w_accept;
  logic [NB_CHANNELS-1:0] w_next_data;

  // Plain flop chain: nothing may sit between stages.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int k = 0; k < NB_STAGES; k++) begin
        r_sync[k] <= {NB_CHANNELS{RESET_LEVEL}};
      end
    end else begin
      r_sync[0] <= i_data;
      for (int k = 1; k < NB_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign w_s = r_sync[NB_STAGES-1];

  always_comb begin
    w_accept = '0;
    for (int n = 0; n < NB_CHANNELS; n++) begin
      w_next_cnt[n] = '0;
      if (w_s[n] != o_data[n]) begin
        if (r_cnt[n] == CNT_LAST) begin
          w_accept[n] = 1'b1;
        end else begin
          w_next_cnt[n] = r_cnt[n] + 1'b1;
        end
      end
    end
    w_next_data = (o_data & ~w_accept) | (w_s & w_accept);
  end

  // Strobes are registered alongside o_data so they mark the first cycle of the new level.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int n = 0; n < NB_CHANNELS; n++) begin
        r_cnt[n] <= '0;
      end
      o_data  <= {NB_CHANNELS{RESET_LEVEL}};
      o_rise  <= '0;
      o_fall  <= '0;
      o_busy  <= '0;
      o_event <= 1'b0;
    end else begin
      for (int n = 0; n < NB_CHANNELS; n++) begin
        r_cnt[n]  <= w_next_cnt[n];
        o_busy[n] <= (w_next_cnt[n] != '0);
      end
      o_data  <= w_next_data;
      o_rise  <= w_accept & w_s;
      o_fall  <= w_accept & ~w_s;
      o_event <= |w_accept;
    end
  end

endmodule

// File: tb/tb_sync_filter_bank.sv
// tb/tb_sync_filter_bank.sv - table-driven scoreboard bench for sync_filter_bank
module tb_sync_filter_bank;

  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] din;
    logic [3:0] data;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] busy;
    logic       ev;
  } vec_t;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic [3:0] i_data = 4'hF;
  logic [3:0] o_data, o_rise, o_fall, o_busy;
  logic       o_event;
  logic [0:0] i_data1 = 1'b0;
  logic [0:0] o_data1, o_rise1, o_fall1, o_busy1;
  logic       o_event1;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_vec = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  sync_filter_bank u_dut (
    .i_clock(clk), .i_reset(i_reset), .i_data(i_data),
    .o_data(o_data), .o_rise(o_rise), .o_fall(o_fall),
    .o_busy(o_busy), .o_event(o_event)
  );

  sync_filter_bank #(.NB_CHANNELS(1), .NB_STAGES(3), .FILTER_CYCLES(1)) u_dut1 (
    .i_clock(clk), .i_reset(i_reset), .i_data(i_data1),
    .o_data(o_data1), .o_rise(o_rise1), .o_fall(o_fall1),
    .o_busy(o_busy1), .o_event(o_event1)
  );

  task automatic add(input string nm, input logic rst, input logic [3:0] din,
                     input logic [3:0] data, input logic [3:0] rise, input logic [3:0] fall,
                     input logic [3:0] busy, input logic ev);
    vec_t v;
    v.name = nm; v.rst = rst; v.din = din; v.data = data;
    v.rise = rise; v.fall = fall; v.busy = busy; v.ev = ev;
    vecs.push_back(v);
  endtask

  // Clean level change from old_d to new_d: busy on edges 3..5, accepted on edge 6.
  task automatic add_change(input string nm, input logic [3:0] din,
                            input logic [3:0] old_d, input logic [3:0] new_d);
    logic [3:0] diff;
    diff = old_d ^ new_d;
    add(nm, 1'b0, din, old_d, 4'h0, 4'h0, 4'h0, 1'b0);
    add(nm, 1'b0, din, old_d, 4'h0, 4'h0, 4'h0, 1'b0);
    add(nm, 1'b0, din, old_d, 4'h0, 4'h0, diff, 1'b0);
    add(nm, 1'b0, din, old_d, 4'h0, 4'h0, diff, 1'b0);
    add(nm, 1'b0, din, old_d, 4'h0, 4'h0, diff, 1'b0);
    add(nm, 1'b0, din, new_d, new_d & ~old_d, old_d & ~new_d, 4'h0, |diff);
    add(nm, 1'b0, din, new_d, 4'h0, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic check(input vec_t e, input int idx);
    n_vec++;
    if (o_data !== e.data || o_rise !== e.rise || o_fall !== e.fall ||
        o_busy !== e.busy || o_event !== e.ev) begin
      n_miss++;
      $display("FAIL %s[%0d]: got data=%h rise=%h fall=%h busy=%h ev=%b want data=%h rise=%h fall=%h busy=%h ev=%b",
               e.name, idx, o_data, o_rise, o_fall, o_busy, o_event,
               e.data, e.rise, e.fall, e.busy, e.ev);
    end
  endtask

  initial begin
    vec_t e;
    logic hist[$];
    logic [15:0] pat;
    logic exp_d, prv_d;

    // Reset with inputs high, then release and accept 4'hF.
    for (int i = 0; i < 3; i++) add("reset_hold", 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    add_change("post_reset", 4'hF, 4'h0, 4'hF);
    add("post_reset", 1'b0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0);
    // Three-cycle glitch on ch0 is rejected.
    add("reset2", 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    add("idle", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 8; i++)
      add("glitch3", 1'b0, (i < 3) ? 4'h1 : 4'h0, 4'h0, 4'h0, 4'h0,
          (i >= 2 && i <= 4) ? 4'h1 : 4'h0, 1'b0);
    // Four-cycle pulse on ch0 is accepted, then falls four cycles later.
    add("pulse4", 1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    add("pulse4", 1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    add("pulse4", 1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 1'b0);
    add("pulse4", 1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 1'b0);
    add("pulse4", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 1'b0);
    add("pulse4", 1'b0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 1'b1);
    add("pulse4", 1'b0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 1'b0);
    add("pulse4", 1'b0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 1'b0);
    add("pulse4", 1'b0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 1'b0);
    add("pulse4", 1'b0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 1'b1);
    add("pulse4", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    // Simultaneous rise on ch1 and fall on ch2.
    add("reset3", 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    add_change("set_0100", 4'h4, 4'h0, 4'h4);
    add_change("swap_12", 4'h2, 4'h4, 4'h2);
    // Reset aborts a count on ch3 at cnt=2, then the level is re-accepted.
    add("reset4", 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    add("abort", 1'b0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    add("abort", 1'b0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    add("abort", 1'b0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h8, 1'b0);
    add("abort", 1'b0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h8, 1'b0);
    add("abort_rst", 1'b1, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    add_change("reaccept", 4'h8, 4'h0, 4'h8);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      i_reset = vecs[i].rst;
      i_data  = vecs[i].din;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check(e, i);
    end

    // Three-stage, unfiltered single channel: o_data is i_data delayed by 3 edges.
    @(negedge clk);
    i_reset = 1'b1;
    i_data1 = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (o_data1 !== 1'b0 || o_rise1 !== 1'b0 || o_fall1 !== 1'b0 || o_event1 !== 1'b0) begin
      n_miss++;
      $display("FAIL nofilt_reset: got data=%b rise=%b fall=%b ev=%b want all 0",
               o_data1, o_rise1, o_fall1, o_event1);
    end
    for (int i = 0; i < 4; i++) hist.push_back(1'b0);
    pat = 16'b0000_0101_1001_1010;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      i_reset = 1'b0;
      i_data1 = pat[k];
      hist.push_back(pat[k]);
      exp_d = hist[hist.size()-4];
      prv_d = hist[hist.size()-5];
      @(posedge clk);
      #1;
      n_vec++;
      if (o_data1 !== exp_d || o_rise1 !== (exp_d & ~prv_d) || o_fall1 !== (prv_d & ~exp_d) ||
          o_busy1 !== 1'b0 || o_event1 !== (exp_d ^ prv_d)) begin
        n_miss++;
        $display("FAIL nofilt[%0d]: got data=%b rise=%b fall=%b busy=%b ev=%b want data=%b rise=%b fall=%b busy=0 ev=%b",
                 k, o_data1, o_rise1, o_fall1, o_busy1, o_event1,
                 exp_d, exp_d & ~prv_d, prv_d & ~exp_d, exp_d ^ prv_d);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
